// File: rtl/npu_pkg.sv
// Shared NPU constants, the per-beat requantisation config record and a
// shift-capping helper used by the requantisation output stage.
package npu_pkg;

    localparam int ACC_WIDTH   = 32;
    localparam int MULT_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 6;
    localparam int OUT_WIDTH   = 8;

    // Full-precision product and the one-bit-wider rounding sum.
    localparam int PROD_WIDTH  = ACC_WIDTH + MULT_WIDTH;
    localparam int ROUND_WIDTH = PROD_WIDTH + 1;
    localparam int MAX_SHIFT   = PROD_WIDTH - 1;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef struct packed {
        logic signed [MULT_WIDTH-1:0]  mult;
        logic        [SHIFT_WIDTH-1:0] shift;
        logic signed [OUT_WIDTH-1:0]   zero_point;
        logic                          relu_en;
    } requant_cfg_t;

    // Shifting a 48-bit product by more than 47 gives nothing new, so cap it.
    function automatic logic [SHIFT_WIDTH-1:0] cap_shift(input logic [SHIFT_WIDTH-1:0] s);
        return (s > SHIFT_WIDTH'(MAX_SHIFT)) ? SHIFT_WIDTH'(MAX_SHIFT) : s;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Final output stage: optional ReLU, zero-point add and INT8 saturation.
// Purely combinational so it can be dropped into other output paths.
module requant_sat
    import npu_pkg::*;
#(
    parameter int IN_WIDTH = ROUND_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  r_in,
    input  logic                        relu_en,
    input  logic signed [OUT_WIDTH-1:0] zero_point,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        sat_out
);

    localparam int V_WIDTH = IN_WIDTH + 1;
    localparam logic signed [V_WIDTH-1:0] V_MAX = V_WIDTH'(INT8_MAX);
    localparam logic signed [V_WIDTH-1:0] V_MIN = V_WIDTH'(INT8_MIN);

    logic signed [IN_WIDTH-1:0] r_relu;
    logic signed [V_WIDTH-1:0]  v;

    // ReLU, widen and add zero point, then clamp to the INT8 range.
    always_comb begin
        r_relu   = r_in;
        sat_out  = 1'b0;
        if (relu_en && r_in[IN_WIDTH-1]) begin
            r_relu = '0;
        end
        v        = V_WIDTH'(r_relu) + V_WIDTH'(zero_point);
        data_out = v[OUT_WIDTH-1:0];
        if (v > V_MAX) begin
            data_out = OUT_WIDTH'(INT8_MAX);
            sat_out  = 1'b1;
        end else if (v < V_MIN) begin
            data_out = OUT_WIDTH'(INT8_MIN);
            sat_out  = 1'b1;
        end
    end

endmodule

// File: rtl/requant_unit.sv
// Requantisation unit: INT32 accumulator -> scaled, rounded, ReLU'd, zero-point
// shifted, INT8-saturated result. Three-stage valid/ready pipeline with one
// global advance signal. Optional saturation counter under REQUANT_STATS_EN.
module requant_unit
    import npu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACC_WIDTH-1:0]   in_acc,
    input  logic signed [MULT_WIDTH-1:0]  cfg_mult,
    input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic signed [OUT_WIDTH-1:0]   cfg_zero_point,
    input  logic                          cfg_relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_sat,
    input  logic                          stats_clear,
    output logic [15:0]                   sat_count
);

    requant_cfg_t in_cfg;
    logic         advance;

    logic                          s1_valid_q, s1_valid_d;
    logic signed [PROD_WIDTH-1:0]  s1_prod_q, s1_prod_d;
    logic        [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
    logic signed [OUT_WIDTH-1:0]   s1_zp_q, s1_zp_d;
    logic                          s1_relu_q, s1_relu_d;

    logic                          s2_valid_q, s2_valid_d;
    logic signed [ROUND_WIDTH-1:0] s2_r_q, s2_r_d;
    logic signed [OUT_WIDTH-1:0]   s2_zp_q, s2_zp_d;
    logic                          s2_relu_q, s2_relu_d;

    logic                          s3_valid_q, s3_valid_d;
    logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                          out_sat_q, out_sat_d;

    logic signed [PROD_WIDTH-1:0]  prod;
    logic        [SHIFT_WIDTH-1:0] sh;
    logic signed [ROUND_WIDTH-1:0] r_ext, bias, round_sum, round_r;
    logic signed [OUT_WIDTH-1:0]   sat_data;
    logic                          sat_flag;

    assign in_cfg = '{mult: cfg_mult, shift: cfg_shift,
                      zero_point: cfg_zero_point, relu_en: cfg_relu_en};

    assign advance   = !s3_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // S1 multiply and S2 round-half-up arithmetic shift (49-bit sum cannot overflow).
    always_comb begin
        prod      = PROD_WIDTH'(in_acc) * PROD_WIDTH'($signed(in_cfg.mult));
        sh        = cap_shift(s1_shift_q);
        r_ext     = {s1_prod_q[PROD_WIDTH-1], s1_prod_q};
        bias      = '0;
        if (sh != '0) begin
            bias = ROUND_WIDTH'(1) << (sh - 6'd1);
        end
        round_sum = r_ext + bias;
        round_r   = (sh == '0) ? r_ext : (round_sum >>> sh);
    end

    requant_sat #(.IN_WIDTH(ROUND_WIDTH)) u_sat (
        .r_in       (s2_r_q),
        .relu_en    (s2_relu_q),
        .zero_point (s2_zp_q),
        .data_out   (sat_data),
        .sat_out    (sat_flag)
    );

    // Pipeline next state: everything holds unless advancing; bubbles leave data alone.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_shift_d = s1_shift_q;
        s1_zp_d    = s1_zp_q;
        s1_relu_d  = s1_relu_q;
        s2_valid_d = s2_valid_q;
        s2_r_d     = s2_r_q;
        s2_zp_d    = s2_zp_q;
        s2_relu_d  = s2_relu_q;
        s3_valid_d = s3_valid_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_prod_d  = prod;
                s1_shift_d = in_cfg.shift;
                s1_zp_d    = in_cfg.zero_point;
                s1_relu_d  = in_cfg.relu_en;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_r_d    = round_r;
                s2_zp_d   = s1_zp_q;
                s2_relu_d = s1_relu_q;
            end
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = sat_data;
                out_sat_d  = sat_flag;
            end
        end
    end

    // Pipeline registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_shift_q <= '0;
            s1_zp_q    <= '0;
            s1_relu_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_r_q     <= '0;
            s2_zp_q    <= '0;
            s2_relu_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_shift_q <= s1_shift_d;
            s1_zp_q    <= s1_zp_d;
            s1_relu_q  <= s1_relu_d;
            s2_valid_q <= s2_valid_d;
            s2_r_q     <= s2_r_d;
            s2_zp_q    <= s2_zp_d;
            s2_relu_q  <= s2_relu_d;
            s3_valid_q <= s3_valid_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

`ifdef REQUANT_STATS_EN
    logic [15:0] sat_count_q, sat_count_d;

    // Count saturated handshakes, sticking at all-ones; clear wins over increment.
    always_comb begin
        sat_count_d = sat_count_q;
        if (stats_clear) begin
            sat_count_d = '0;
        end else if (s3_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_stats_clear;
    assign unused_stats_clear = stats_clear;
    assign sat_count          = '0;
`endif

endmodule

// File: tb/tb_requant_unit.sv
// Testbench for requant_unit: directed corner beats, backpressure, reset
// mid-stream, stats counter (REQUANT_STATS_EN) and a randomized stream, all
// scored against an arithmetic reference model.
module tb_requant_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [7:0]  cfg_zero_point;
    logic        cfg_relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        stats_clear;
    logic [15:0] sat_count;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [8:0]  expQ[$];
    logic [7:0]  nextData;
    logic        nextSat;
    bit          prevStall = 1'b0;
    logic [7:0]  prevData;
    logic        prevSat;

    requant_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_acc         (in_acc),
        .cfg_mult       (cfg_mult),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .cfg_relu_en    (cfg_relu_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sat        (out_sat),
        .stats_clear    (stats_clear),
        .sat_count      (sat_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard time limit so a wedged run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact integer arithmetic with floor division for the shift.
    task automatic modelBeat(input int acc, input int mult, input int shift, input int zp,
                             input int relu, output logic [7:0] d, output logic s);
        longint prod, num, den, r, v;
        int sh;
        prod = longint'(acc) * longint'(mult);
        sh   = (shift > 47) ? 47 : shift;
        if (sh == 0) begin
            r = prod;
        end else begin
            den = longint'(2) ** sh;
            num = prod + den / 2;
            r   = num / den;
            if ((num % den) != 0 && num < 0) r = r - 1;
        end
        if (relu != 0 && r < 0) r = 0;
        v = r + longint'(zp);
        s = 1'b0;
        if (v > 127) begin
            d = 8'd127; s = 1'b1;
        end else if (v < -128) begin
            d = 8'h80;  s = 1'b1;
        end else begin
            d = v[7:0];
        end
    endtask

    task automatic applyStimulus(input int acc, input int mult, input int shift,
                                 input int zp, input int relu);
        in_valid       = 1'b1;
        in_acc         = acc;
        cfg_mult       = mult[15:0];
        cfg_shift      = shift[5:0];
        cfg_zero_point = zp[7:0];
        cfg_relu_en    = relu[0];
        modelBeat(acc, mult, shift, zp, relu, nextData, nextSat);
    endtask

    // One clock: score handshakes, check hold-under-stall, then advance to next negedge.
    task automatic tick(output bit accepted);
        logic [8:0] e;
        bit outFire;
        #1;
        accepted = in_valid && in_ready;
        outFire  = out_valid && out_ready;
        if (prevStall) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data", 32'(out_data), 32'(prevData));
            checkOutput("hold_sat", 32'(out_sat), 32'(prevSat));
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
        prevSat   = out_sat;
        if (outFire) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(e[7:0]));
                checkOutput("out_sat", 32'(out_sat), 32'(e[8]));
            end
        end
        if (accepted) expQ.push_back({nextSat, nextData});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic runDirected(input string tag, input int acc, input int mult, input int shift,
                               input int zp, input int relu, input logic [7:0] expData,
                               input logic expSat);
        bit a;
        out_ready = 1'b1;
        applyStimulus(acc, mult, shift, zp, relu);
        nextData = expData;
        nextSat  = expSat;
        tick(a);
        checkOutput({tag, "_accept"}, 32'(a), 32'd1);
        idle(4);
        checkOutput({tag, "_drained"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        bit a;
        int sent, stallLeft;
        bit seenFirst;
        int acc, mult;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stats_clear = 1'b0;
        in_acc = '0; cfg_mult = '0; cfg_shift = '0; cfg_zero_point = '0; cfg_relu_en = 1'b0;
        @(negedge clk); @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] scale and latency");
        out_ready = 1'b1;
        applyStimulus(200, 16384, 15, 0, 0);
        nextData = 8'd100; nextSat = 1'b0;
        tick(a);
        checkOutput("lat_accept", 32'(a), 32'd1);
        in_valid = 1'b0;
        checkOutput("lat_c1", 32'(out_valid), 32'd0);
        tick(a);
        checkOutput("lat_c2", 32'(out_valid), 32'd0);
        tick(a);
        checkOutput("lat_c3", 32'(out_valid), 32'd1);
        idle(2);
        checkOutput("lat_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] directed corners");
        runDirected("round_pos", 3, 1, 1, 0, 0, 8'd2, 1'b0);
        runDirected("round_neg", -3, 1, 1, 0, 0, 8'hFF, 1'b0);
        runDirected("shift0", 5, 1, 0, 0, 0, 8'd5, 1'b0);
        runDirected("sat_hi", 1000, 1, 0, 0, 0, 8'd127, 1'b1);
        runDirected("sat_lo", -1000, 1, 0, 0, 0, 8'h80, 1'b1);
        runDirected("shift63", -1, 1, 63, 0, 0, 8'd0, 1'b0);
        runDirected("relu_zp", -50, 1, 0, 10, 1, 8'd10, 1'b0);
        runDirected("norelu_zp", -50, 1, 0, 10, 0, 8'hD8, 1'b0);
        runDirected("edge127", 127, 1, 0, 0, 0, 8'd127, 1'b0);
        runDirected("edge128", 128, 1, 0, 0, 0, 8'd127, 1'b1);
        runDirected("edge_m128", -128, 1, 0, 0, 0, 8'h80, 1'b0);
        runDirected("zp_push", 120, 1, 0, 10, 0, 8'd127, 1'b1);

        $display("[TB] backpressure");
        sent = 0; stallLeft = 0; seenFirst = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && (sent < 6 || expQ.size() > 0); cyc++) begin
            if (sent < 6) applyStimulus(sent + 1, 1, 0, 0, 0);
            else in_valid = 1'b0;
            if (!seenFirst && out_valid) begin
                seenFirst = 1'b1;
                stallLeft = 5;
            end
            if (stallLeft > 0) begin
                out_ready = 1'b0;
                #1;
                checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
                checkOutput("bp_hold_data", 32'(out_data), 32'd1);
                stallLeft--;
            end else begin
                out_ready = 1'b1;
            end
            tick(a);
            if (a) sent++;
        end
        checkOutput("bp_all_sent", 32'(sent), 32'd6);
        checkOutput("bp_drained", 32'(expQ.size()), 32'd0);
        in_valid = 1'b0;

        $display("[TB] reset mid-stream");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10 + i, 1, 0, 0, 0);
            tick(a);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'd0);
        expQ.delete();
        prevStall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("postrst_quiet", 32'(out_valid), 32'd0);
            tick(a);
        end

        $display("[TB] stats");
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1000 + i, 1, 0, 0, 0);
            tick(a);
        end
        idle(5);
`ifdef REQUANT_STATS_EN
        checkOutput("sat_count_5", 32'(sat_count), 32'd5);
        stats_clear = 1'b1;
        tick(a);
        stats_clear = 1'b0;
        checkOutput("sat_count_clr", 32'(sat_count), 32'd0);
`else
        checkOutput("sat_count_tied", 32'(sat_count), 32'd0);
        stats_clear = 1'b1;
        tick(a);
        stats_clear = 1'b0;
        checkOutput("sat_count_tied2", 32'(sat_count), 32'd0);
`endif

        $display("[TB] random stream");
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 1) == 0) acc = int'($urandom);
            else acc = int'($urandom_range(0, 4000)) - 2000;
            mult = int'($urandom_range(0, 65535)) - 32768;
            applyStimulus(acc, mult, int'($urandom_range(0, 63)),
                          int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            tick(a);
        end
        out_ready = 1'b1;
        idle(6);
        checkOutput("rand_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
